// File: rtl/us_cmd_sched_if.sv
// us_cmd_sched_if
// Bundles the two handshakes the upstream command scheduler sits between:
//   - command FIFO (first-word-fall-through): us_cmd_fifo_empty_i,
//     us_cmd_fifo_dout_i[127:0] toward the scheduler, us_cmd_fifo_rd_en_o back
//   - TX TLP engine: tx_req_o, tx_addr_o[31:0], tx_len_dw_o[7:0] toward the
//     engine, tx_ack_i and tx_done_i back
// Signal names keep the scheduler's point of view (_i = into the scheduler).
// modport master: the scheduler; modport slave: the FIFO / TX engine side.
interface us_cmd_sched_if;
    logic         us_cmd_fifo_empty_i;
    logic [127:0] us_cmd_fifo_dout_i;
    logic         us_cmd_fifo_rd_en_o;
    logic         tx_req_o;
    logic [31:0]  tx_addr_o;
    logic [7:0]   tx_len_dw_o;
    logic         tx_ack_i;
    logic         tx_done_i;

    modport master (
        input  us_cmd_fifo_empty_i,
        input  us_cmd_fifo_dout_i,
        output us_cmd_fifo_rd_en_o,
        output tx_req_o,
        output tx_addr_o,
        output tx_len_dw_o,
        input  tx_ack_i,
        input  tx_done_i
    );

    modport slave (
        output us_cmd_fifo_empty_i,
        output us_cmd_fifo_dout_i,
        input  us_cmd_fifo_rd_en_o,
        input  tx_req_o,
        input  tx_addr_o,
        input  tx_len_dw_o,
        output tx_ack_i,
        output tx_done_i
    );
endinterface

// File: rtl/us_cmd_sched.sv
// us_cmd_sched
// Upstream command scheduler. Pops one 128-bit command from the command FIFO,
// splits it into memory-write TLP requests of at most MAX_PAYLOAD_BYTES that
// never cross a 4 KB boundary, runs each through the TX engine's req/ack/done
// handshake and finally pulses a completion carrying the command id.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   sched_en_i      allows a new command to be popped (checked only in IDLE)
//   bus             FIFO + TX engine handshakes (us_cmd_sched_if.master)
//   cmd_compl_o     one-cycle completion pulse
//   cmd_id_o        id of the completing command, valid with cmd_compl_o
//   cmd_err_o       pulses with cmd_compl_o when the command was rejected
//   busy_o          high whenever the scheduler is not idle
// All outputs are registered: each output flop is loaded from the value it
// must carry in the next state.
module us_cmd_sched #(
    parameter int         MAX_PAYLOAD_BYTES = 128,
    parameter logic [1:0] WR32_TYPE         = 2'b01,
    parameter int         MAX_LEN_CODE      = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sched_en_i,
    us_cmd_sched_if.master     bus,
    output logic               cmd_compl_o,
    output logic [1:0]         cmd_id_o,
    output logic               cmd_err_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {IDLE, POP, CHECK, CALC, REQ, WAIT_DONE, COMPL} state_t;

    localparam logic [12:0] MPS      = 13'(MAX_PAYLOAD_BYTES);
    localparam logic [4:0]  MAX_CODE = 5'(MAX_LEN_CODE);

    state_t      state_q, state_d;
    logic [1:0]  cmd_type_q, cmd_type_d;
    logic [4:0]  code_q, code_d;
    logic [1:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [12:0] remaining_q, remaining_d;
    logic [12:0] chunk_q, chunk_d;
    logic        err_q, err_d;
    logic        rd_en_q, rd_en_d;
    logic        tx_req_q, tx_req_d;
    logic [31:0] tx_addr_q, tx_addr_d;
    logic [7:0]  tx_len_q, tx_len_d;
    logic        compl_q, compl_d;
    logic [1:0]  id_out_q, id_out_d;
    logic        err_out_q, err_out_d;
    logic        busy_q, busy_d;

    logic [12:0] room_c;
    logic [12:0] chunk_c;
    logic [12:0] remaining_next_c;

    // Fields of the FIFO word the scheduler has no use for.
    logic unused_dout_bits;
    assign unused_dout_bits = ^{bus.us_cmd_fifo_dout_i[127:64],
                                bus.us_cmd_fifo_dout_i[54:32],
                                bus.us_cmd_fifo_dout_i[1:0]};

    // Next-state and datapath. The chunk is the smallest of what is left, the
    // max payload and the distance to the next 4 KB boundary.
    always_comb begin
        state_d     = state_q;
        cmd_type_d  = cmd_type_q;
        code_d      = code_q;
        id_d        = id_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        err_d       = err_q;
        tx_addr_d   = tx_addr_q;
        tx_len_d    = tx_len_q;

        room_c = 13'd4096 - {1'b0, addr_q[11:0]};
        chunk_c = remaining_q;
        if (MPS < chunk_c) begin
            chunk_c = MPS;
        end
        if (room_c < chunk_c) begin
            chunk_c = room_c;
        end
        remaining_next_c = remaining_q - chunk_q;

        unique case (state_q)
            IDLE: begin
                if (sched_en_i && !bus.us_cmd_fifo_empty_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                cmd_type_d = bus.us_cmd_fifo_dout_i[63:62];
                code_d     = bus.us_cmd_fifo_dout_i[61:57];
                id_d       = bus.us_cmd_fifo_dout_i[56:55];
                addr_d     = {bus.us_cmd_fifo_dout_i[31:2], 2'b00};
                // Codes above 12 shift out to zero; they are rejected in CHECK.
                remaining_d = 13'd1 << bus.us_cmd_fifo_dout_i[61:57];
                state_d    = CHECK;
            end
            CHECK: begin
                if (cmd_type_q != WR32_TYPE || code_q < 5'd2 || code_q > MAX_CODE) begin
                    err_d   = 1'b1;
                    state_d = COMPL;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                chunk_d   = chunk_c;
                tx_addr_d = addr_q;
                tx_len_d  = 8'(chunk_c >> 2);
                state_d   = REQ;
            end
            REQ: begin
                if (bus.tx_ack_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_i) begin
                    addr_d      = addr_q + {19'd0, chunk_q};
                    remaining_d = remaining_next_c;
                    state_d     = (remaining_next_c == 13'd0) ? COMPL : CALC;
                end
            end
            COMPL: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d   = (state_d == POP);
        tx_req_d  = (state_d == REQ);
        compl_d   = (state_d == COMPL);
        id_out_d  = (state_d == COMPL) ? id_d : 2'd0;
        err_out_d = (state_d == COMPL) && err_d;
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight command silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_type_q  <= 2'd0;
            code_q      <= 5'd0;
            id_q        <= 2'd0;
            addr_q      <= 32'd0;
            remaining_q <= 13'd0;
            chunk_q     <= 13'd0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_addr_q   <= 32'd0;
            tx_len_q    <= 8'd0;
            compl_q     <= 1'b0;
            id_out_q    <= 2'd0;
            err_out_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_type_q  <= cmd_type_d;
            code_q      <= code_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            tx_req_q    <= tx_req_d;
            tx_addr_q   <= tx_addr_d;
            tx_len_q    <= tx_len_d;
            compl_q     <= compl_d;
            id_out_q    <= id_out_d;
            err_out_q   <= err_out_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.us_cmd_fifo_rd_en_o = rd_en_q;
    assign bus.tx_req_o            = tx_req_q;
    assign bus.tx_addr_o           = tx_addr_q;
    assign bus.tx_len_dw_o         = tx_len_q;
    assign cmd_compl_o             = compl_q;
    assign cmd_id_o                = id_out_q;
    assign cmd_err_o               = err_out_q;
    assign busy_o                  = busy_q;

endmodule
